kfmmc_data_io: RTL and testbench

- Byte-level data-line transfer sequencer between the MMC host controller's register/CPU side and the low-level MMC serial engine.
- On a start request it latches the direction, the byte and option flags.
- It waits for the serial engine to become idle, issues a one-cycle start command, and then waits for the engine's sent or received completion interrupt.
- For receives it captures the received byte and then returns to idle.

---
 rtl/kfmmc_data_io.sv | 154 +++++++++++++++
 tb/tb_kfmmc_data_io.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/kfmmc_data_io.sv
// kfmmc_data_io: byte-level data-line transfer sequencer between the MMC
// host register side and the MMC serial engine. Latches a request, waits for
// the engine to be idle, issues a single start pulse, then waits for the
// matching sent/received completion interrupt.
module kfmmc_data_io (
    input  logic       clock,
    input  logic       reset,
    input  logic       disable_data_io,
    input  logic       start_data_io,
    input  logic       check_data_start_bit,
    input  logic       clear_data_crc,
    input  logic       data_io,
    input  logic [7:0] transmit_data,
    output logic       data_io_busy,
    output logic [7:0] received_data,
    output logic       start_communication_to_mmc,
    output logic       data_io_to_mmc,
    output logic       check_data_start_bit_to_mmc,
    output logic       clear_data_crc_to_mmc,
    output logic       clear_data_interrupt_to_mmc,
    output logic       mask_data_interrupt_to_mmc,
    output logic       set_send_data_to_mmc,
    output logic [7:0] send_data_to_mmc,
    input  logic [7:0] received_data_from_mmc,
    input  logic       mmc_is_in_connecting,
    input  logic       sent_data_interrupt_from_mmc,
    input  logic       received_data_interrupt_from_mmc
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] WAIT_READY  = 3'd1;
    localparam logic [2:0] ISSUE       = 3'd2;
    localparam logic [2:0] WAIT_ACCEPT = 3'd3;
    localparam logic [2:0] WAIT_DONE   = 3'd4;

    logic [2:0] state_q, state_d;
    logic       chk_q, chk_d;
    logic       crc_q, crc_d;
    logic       dir_q, dir_d;
    logic [7:0] send_q, send_d;
    logic [7:0] rx_q, rx_d;
    logic       busy_q, busy_d;
    logic       mask_q, mask_d;
    logic       start_q, start_d;
    logic       chk_out_q, chk_out_d;
    logic       crc_out_q, crc_out_d;
    logic       clr_int_q, clr_int_d;
    logic       set_send_q, set_send_d;
    logic       issue;
    logic       done_irq;

    // Next-state, latch and output computation; outputs are decoded from the
    // next state so every output is a flop.
    always_comb begin
        state_d  = state_q;
        chk_d    = chk_q;
        crc_d    = crc_q;
        dir_d    = dir_q;
        send_d   = send_q;
        rx_d     = rx_q;
        done_irq = dir_q ? received_data_interrupt_from_mmc
                         : sent_data_interrupt_from_mmc;

        if (disable_data_io) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_data_io) begin
                        state_d = WAIT_READY;
                        chk_d   = check_data_start_bit;
                        crc_d   = clear_data_crc;
                        dir_d   = data_io;
                        send_d  = transmit_data;
                    end
                end
                WAIT_READY: begin
                    if (!mmc_is_in_connecting) state_d = ISSUE;
                end
                ISSUE: begin
                    state_d = WAIT_ACCEPT;
                end
                // Interrupts are deliberately not looked at here: they may be
                // left over from the previous transfer.
                WAIT_ACCEPT: begin
                    if (mmc_is_in_connecting) state_d = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!mmc_is_in_connecting && done_irq) begin
                        state_d = IDLE;
                        if (dir_q) rx_d = received_data_from_mmc;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        issue      = (state_d == ISSUE);
        start_d    = issue;
        clr_int_d  = issue;
        set_send_d = issue && !dir_d;
        chk_out_d  = issue && chk_d;
        crc_out_d  = issue && crc_d;
        busy_d     = (state_d != IDLE);
        mask_d     = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            chk_q      <= 1'b0;
            crc_q      <= 1'b0;
            dir_q      <= 1'b0;
            send_q     <= 8'h00;
            rx_q       <= 8'h00;
            busy_q     <= 1'b0;
            mask_q     <= 1'b0;
            start_q    <= 1'b0;
            chk_out_q  <= 1'b0;
            crc_out_q  <= 1'b0;
            clr_int_q  <= 1'b0;
            set_send_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            chk_q      <= chk_d;
            crc_q      <= crc_d;
            dir_q      <= dir_d;
            send_q     <= send_d;
            rx_q       <= rx_d;
            busy_q     <= busy_d;
            mask_q     <= mask_d;
            start_q    <= start_d;
            chk_out_q  <= chk_out_d;
            crc_out_q  <= crc_out_d;
            clr_int_q  <= clr_int_d;
            set_send_q <= set_send_d;
        end
    end

    assign data_io_busy                = busy_q;
    assign received_data               = rx_q;
    assign start_communication_to_mmc  = start_q;
    assign data_io_to_mmc              = dir_q;
    assign check_data_start_bit_to_mmc = chk_out_q;
    assign clear_data_crc_to_mmc       = crc_out_q;
    assign clear_data_interrupt_to_mmc = clr_int_q;
    assign mask_data_interrupt_to_mmc  = mask_q;
    assign set_send_data_to_mmc        = set_send_q;
    assign send_data_to_mmc            = send_q;

endmodule

// File: tb/tb_kfmmc_data_io.sv
// Directed bench for kfmmc_data_io: send/receive transfers with CRC and
// start-bit flags, stale/non-matching interrupts, disable and reset.
module tb_kfmmc_data_io;

    logic       clock = 1'b0;
    logic       reset;
    logic       disable_data_io;
    logic       start_data_io;
    logic       check_data_start_bit;
    logic       clear_data_crc;
    logic       data_io;
    logic [7:0] transmit_data;
    logic       data_io_busy;
    logic [7:0] received_data;
    logic       start_communication_to_mmc;
    logic       data_io_to_mmc;
    logic       check_data_start_bit_to_mmc;
    logic       clear_data_crc_to_mmc;
    logic       clear_data_interrupt_to_mmc;
    logic       mask_data_interrupt_to_mmc;
    logic       set_send_data_to_mmc;
    logic [7:0] send_data_to_mmc;
    logic [7:0] received_data_from_mmc;
    logic       mmc_is_in_connecting;
    logic       sent_data_interrupt_from_mmc;
    logic       received_data_interrupt_from_mmc;

    int unsigned vec  = 0;
    int unsigned miss = 0;
    logic [7:0]  exp_rx;

    kfmmc_data_io dut (
        .clock                            (clock),
        .reset                            (reset),
        .disable_data_io                  (disable_data_io),
        .start_data_io                    (start_data_io),
        .check_data_start_bit             (check_data_start_bit),
        .clear_data_crc                   (clear_data_crc),
        .data_io                          (data_io),
        .transmit_data                    (transmit_data),
        .data_io_busy                     (data_io_busy),
        .received_data                    (received_data),
        .start_communication_to_mmc       (start_communication_to_mmc),
        .data_io_to_mmc                   (data_io_to_mmc),
        .check_data_start_bit_to_mmc      (check_data_start_bit_to_mmc),
        .clear_data_crc_to_mmc            (clear_data_crc_to_mmc),
        .clear_data_interrupt_to_mmc      (clear_data_interrupt_to_mmc),
        .mask_data_interrupt_to_mmc       (mask_data_interrupt_to_mmc),
        .set_send_data_to_mmc             (set_send_data_to_mmc),
        .send_data_to_mmc                 (send_data_to_mmc),
        .received_data_from_mmc           (received_data_from_mmc),
        .mmc_is_in_connecting             (mmc_is_in_connecting),
        .sent_data_interrupt_from_mmc     (sent_data_interrupt_from_mmc),
        .received_data_interrupt_from_mmc (received_data_interrupt_from_mmc)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse outputs packed as {start, clr_int, set_send, chk_bit, crc}
    function automatic logic [7:0] pulses();
        return {3'b000, start_communication_to_mmc, clear_data_interrupt_to_mmc,
                set_send_data_to_mmc, check_data_start_bit_to_mmc, clear_data_crc_to_mmc};
    endfunction

    task automatic xfer(input string tag, input logic dir, input logic [7:0] tx,
                        input logic [7:0] rx, input logic cbit, input logic crc);
        logic [7:0] issue_exp;
        issue_exp = {3'b000, 1'b1, 1'b1, !dir, cbit, crc};
        start_data_io = 1'b1; data_io = dir; transmit_data = tx;
        check_data_start_bit = cbit; clear_data_crc = crc;
        mmc_is_in_connecting = 1'b1;
        tick();
        start_data_io = 1'b0; transmit_data = 8'h00; data_io = !dir;
        check_data_start_bit = 1'b0; clear_data_crc = 1'b0;
        chk({tag, "_busy_on"}, {7'd0, data_io_busy}, 8'd1);
        chk({tag, "_mask_on"}, {7'd0, mask_data_interrupt_to_mmc}, 8'd1);
        chk({tag, "_dir"}, {7'd0, data_io_to_mmc}, {7'd0, dir});
        chk({tag, "_send_data"}, send_data_to_mmc, tx);
        tick();
        chk({tag, "_no_pulse_wait"}, pulses(), 8'h00);
        mmc_is_in_connecting = 1'b0;
        tick();
        chk({tag, "_issue_pulses"}, pulses(), issue_exp);
        // stale matching interrupt while the engine has not yet accepted
        if (dir) received_data_interrupt_from_mmc = 1'b1;
        else     sent_data_interrupt_from_mmc = 1'b1;
        received_data_from_mmc = 8'h5A;
        tick();
        chk({tag, "_pulse_end"}, pulses(), 8'h00);
        tick();
        chk({tag, "_stale_ignored"}, {7'd0, data_io_busy}, 8'd1);
        sent_data_interrupt_from_mmc = 1'b0; received_data_interrupt_from_mmc = 1'b0;
        mmc_is_in_connecting = 1'b1;
        tick();
        mmc_is_in_connecting = 1'b0;
        tick();
        mmc_is_in_connecting = 1'b1;
        chk({tag, "_glitch_ignored"}, {7'd0, data_io_busy}, 8'd1);
        mmc_is_in_connecting = 1'b0;
        if (dir) sent_data_interrupt_from_mmc = 1'b1;
        else     received_data_interrupt_from_mmc = 1'b1;
        tick();
        chk({tag, "_wrong_irq_ignored"}, {7'd0, data_io_busy}, 8'd1);
        sent_data_interrupt_from_mmc = 1'b0; received_data_interrupt_from_mmc = 1'b0;
        if (dir) received_data_interrupt_from_mmc = 1'b1;
        else     sent_data_interrupt_from_mmc = 1'b1;
        received_data_from_mmc = rx;
        tick();
        if (dir) exp_rx = rx;
        sent_data_interrupt_from_mmc = 1'b0; received_data_interrupt_from_mmc = 1'b0;
        received_data_from_mmc = 8'h00;
        chk({tag, "_busy_off"}, {7'd0, data_io_busy}, 8'd0);
        chk({tag, "_mask_off"}, {7'd0, mask_data_interrupt_to_mmc}, 8'd0);
        chk({tag, "_received"}, received_data, exp_rx);
        tick();
        chk({tag, "_dir_hold"}, {7'd0, data_io_to_mmc}, {7'd0, dir});
        chk({tag, "_send_hold"}, send_data_to_mmc, tx);
        chk({tag, "_idle_no_pulse"}, pulses(), 8'h00);
    endtask

    initial begin
        reset = 1'b1; disable_data_io = 1'b0; start_data_io = 1'b0;
        check_data_start_bit = 1'b0; clear_data_crc = 1'b0; data_io = 1'b0;
        transmit_data = 8'h00; received_data_from_mmc = 8'h00;
        mmc_is_in_connecting = 1'b0; sent_data_interrupt_from_mmc = 1'b0;
        received_data_interrupt_from_mmc = 1'b0; exp_rx = 8'h00;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", {7'd0, data_io_busy}, 8'd0);
        chk("rst_pulses", pulses(), 8'h00);
        chk("rst_send_data", send_data_to_mmc, 8'h00);
        chk("rst_received", received_data, 8'h00);
        chk("rst_dir_mask", {6'd0, data_io_to_mmc, mask_data_interrupt_to_mmc}, 8'h00);
        tick();

        xfer("send_ab", 1'b0, 8'hAB, 8'h11, 1'b0, 1'b0);
        xfer("recv_cd", 1'b1, 8'h00, 8'hCD, 1'b0, 1'b0);
        xfer("send_ef_crc", 1'b0, 8'hEF, 8'h22, 1'b0, 1'b1);
        xfer("recv_ba_crc", 1'b1, 8'h00, 8'hBA, 1'b0, 1'b1);
        xfer("recv_dc_sbit", 1'b1, 8'h00, 8'hDC, 1'b1, 1'b0);

        // disable at the edge that would enter ISSUE
        start_data_io = 1'b1; data_io = 1'b1; mmc_is_in_connecting = 1'b1;
        tick();
        start_data_io = 1'b0;
        chk("dis_pre_busy", {7'd0, data_io_busy}, 8'd1);
        mmc_is_in_connecting = 1'b0; disable_data_io = 1'b1;
        tick();
        disable_data_io = 1'b0;
        chk("dis_mid_busy", {7'd0, data_io_busy}, 8'd0);
        chk("dis_mid_pulses", pulses(), 8'h00);
        chk("dis_mid_received", received_data, 8'hDC);
        tick();
        chk("dis_mid_stays_idle", {7'd0, data_io_busy}, 8'd0);

        // disable in idle blocks a simultaneous start
        disable_data_io = 1'b1; start_data_io = 1'b1; data_io = 1'b0;
        transmit_data = 8'h77;
        tick();
        disable_data_io = 1'b0; start_data_io = 1'b0;
        chk("dis_idle_busy", {7'd0, data_io_busy}, 8'd0);
        chk("dis_idle_send_data", send_data_to_mmc, 8'h00);
        tick();
        chk("dis_idle_no_pulse", pulses(), 8'h00);

        // reset mid-transfer
        start_data_io = 1'b1; data_io = 1'b0; transmit_data = 8'h55;
        mmc_is_in_connecting = 1'b1;
        tick();
        start_data_io = 1'b0;
        chk("rst2_pre_send_data", send_data_to_mmc, 8'h55);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_busy", {7'd0, data_io_busy}, 8'd0);
        chk("rst2_pulses", pulses(), 8'h00);
        chk("rst2_send_data", send_data_to_mmc, 8'h00);
        chk("rst2_received", received_data, 8'h00);
        chk("rst2_dir_mask", {6'd0, data_io_to_mmc, mask_data_interrupt_to_mmc}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
